// File: rtl/mem_req_pkg.sv
// mem_req_pkg: shared sizes and types for the memory request controller
package mem_req_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int FIFO_DEPTH = 2;
  typedef enum logic {IDLE, WAIT} state_t;
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;
endpackage

// File: rtl/req_fifo.sv
// req_fifo: two-entry request FIFO, push and pop may coincide at any occupancy
module req_fifo
  import mem_req_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  req_t din,
  output req_t dout,
  output logic full,
  output logic empty
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH = (PTR_W + 1)'(FIFO_DEPTH);
  req_t [FIFO_DEPTH-1:0] ent_q, ent_d;
  logic [PTR_W-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [PTR_W:0] cnt_q, cnt_d;
  assign full  = cnt_q == DEPTH;
  assign empty = cnt_q == '0;
  assign dout  = ent_q[rp_q];
  always_comb begin
    ent_d = ent_q;
    ent_d[wp_q] = push ? din : ent_q[wp_q];
    wp_d = push ? wp_q + PTR_W'(1) : wp_q;
    rp_d = pop ? rp_q + PTR_W'(1) : rp_q;
    cnt_d = cnt_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ent_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: buffers pipeline load/store requests and drives the mem_system
// Rd/Wr/Stall/Done handshake, returning one in-order response per request.
module mem_req_ctrl
  import mem_req_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_hit,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_Addr,
  output logic [DATA_W-1:0] mem_DataIn,
  output logic              mem_Rd,
  output logic              mem_Wr,
  input  logic [DATA_W-1:0] mem_DataOut,
  input  logic              mem_Done,
  input  logic              mem_Stall,
  input  logic              mem_CacheHit,
  input  logic              mem_err,
  output logic              busy,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);
  state_t state_q, state_d;
  req_t head, cur, held_q, held_d;
  logic full, empty, push, pop, issue, mis, done;
  logic resp_valid_q, resp_valid_d, resp_hit_q, resp_hit_d, resp_err_q, resp_err_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  req_fifo u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  ({req_wr, req_addr, req_data}),
    .dout (head),
    .full (full),
    .empty(empty)
  );
  assign req_ready = !full;
  assign push  = req_valid & !full;
  assign mis   = (state_q == IDLE) & !empty & head.addr[0];
  assign issue = (state_q == IDLE) & !empty & !head.addr[0] & !mem_Stall;
  assign pop   = mis | issue;
  // The strobe cycle drives the head directly; the held copy keeps the bus stable afterwards.
  assign cur        = issue ? head : held_q;
  assign mem_Addr   = cur.addr;
  assign mem_DataIn = cur.data;
  assign mem_Rd     = issue & !head.wr;
  assign mem_Wr     = issue & head.wr;
  assign done       = mem_Done & (issue | (state_q == WAIT));
  assign busy       = !empty | (state_q == WAIT);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_hit   = resp_hit_q;
  assign resp_err   = resp_err_q;
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;
  always_comb begin
    state_d = issue & !mem_Done ? WAIT : ((state_q == WAIT) & mem_Done ? IDLE : state_q);
    held_d = issue ? head : held_q;
    resp_valid_d = done | mis;
    resp_data_d = done & !cur.wr & !mem_err ? mem_DataOut : '0;
    resp_hit_d = done & mem_CacheHit;
    resp_err_d = mis | (done & mem_err);
    hit_cnt_d = done & !mem_err & mem_CacheHit & !(&hit_cnt_q) ? hit_cnt_q + CNT_W'(1) : hit_cnt_q;
    miss_cnt_d = done & !mem_err & !mem_CacheHit & !(&miss_cnt_q) ? miss_cnt_q + CNT_W'(1) : miss_cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q      <= IDLE;
      held_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_hit_q   <= 1'b0;
      resp_err_q   <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      held_q       <= held_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_hit_q   <= resp_hit_d;
      resp_err_q   <= resp_err_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: cycle vectors, directed corner sequences and a randomized
// transaction-level check of mem_req_ctrl against an in-order response model.
module tb_mem_req_ctrl;
  logic clk = 0, rst = 1;
  logic req_valid, req_wr, mem_Done, mem_Stall, mem_CacheHit, mem_err;
  logic [15:0] req_addr, req_data, mem_DataOut;
  logic req_ready, resp_valid, resp_hit, resp_err, mem_Rd, mem_Wr, busy;
  logic [15:0] resp_data, mem_Addr, mem_DataIn, hit_cnt, miss_cnt;
  logic req_ready_2, resp_valid_2, resp_hit_2, resp_err_2, mem_Rd_2, mem_Wr_2, busy_2;
  logic [15:0] resp_data_2, mem_Addr_2, mem_DataIn_2;
  logic [1:0] hit_cnt_2, miss_cnt_2;

  mem_req_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_data(req_data), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_hit(resp_hit), .resp_err(resp_err), .mem_Addr(mem_Addr), .mem_DataIn(mem_DataIn),
    .mem_Rd(mem_Rd), .mem_Wr(mem_Wr), .mem_DataOut(mem_DataOut), .mem_Done(mem_Done),
    .mem_Stall(mem_Stall), .mem_CacheHit(mem_CacheHit), .mem_err(mem_err), .busy(busy),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  mem_req_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_2), .req_wr(req_wr),
    .req_addr(req_addr), .req_data(req_data), .resp_valid(resp_valid_2), .resp_data(resp_data_2),
    .resp_hit(resp_hit_2), .resp_err(resp_err_2), .mem_Addr(mem_Addr_2), .mem_DataIn(mem_DataIn_2),
    .mem_Rd(mem_Rd_2), .mem_Wr(mem_Wr_2), .mem_DataOut(mem_DataOut), .mem_Done(mem_Done),
    .mem_Stall(mem_Stall), .mem_CacheHit(mem_CacheHit), .mem_err(mem_err), .busy(busy_2),
    .hit_cnt(hit_cnt_2), .miss_cnt(miss_cnt_2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v, wr; logic [15:0] a, d;
    logic st, dn, ht, er; logic [15:0] dout;
    logic rdy, rd, ws; logic [15:0] ma;
    logic rv; logic [15:0] rdat; logic rh, re, bsy;
    logic [15:0] hc, mc;
  } vec_t;
  typedef struct packed { logic wr; logic [15:0] addr; logic [15:0] data; } treq_t;
  typedef struct packed { logic [15:0] d; logic h; logic e; } tres_t;

  vec_t tv [25];
  treq_t req_q[$], aln_q[$], cur_m;
  tres_t res_q[$];
  logic [15:0] mem_m [256];
  int n_chk = 0, n_err = 0, lat = 0, m_hc = 0, m_mc = 0, wcnt = 0;
  bit out_m = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic idle();
    req_valid = 0; req_wr = 0; req_addr = 0; req_data = 0;
    mem_Stall = 0; mem_Done = 0; mem_CacheHit = 0; mem_err = 0; mem_DataOut = 0;
  endtask

  task automatic rand_cycle(input bit gen);
    treq_t r;
    tres_t x;
    logic e;
    @(posedge clk); #1;
    req_valid = gen && ($urandom_range(0, 3) != 0);
    req_wr = 1'($urandom_range(0, 1));
    req_addr = {7'd0, 8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0)};
    req_data = 16'($urandom);
    mem_Stall = ($urandom_range(0, 3) == 0);
    mem_Done = 0;
    mem_err = 0;
    mem_CacheHit = 1'($urandom_range(0, 1));
    mem_DataOut = 16'($urandom);
    #1;
    if (mem_Rd || mem_Wr) begin
      chk("rnd_rd_wr_excl", 32'(mem_Rd & mem_Wr), 0);
      chk("rnd_strobe_while_outstanding", 32'(out_m), 0);
      chk("rnd_strobe_during_stall", 32'(mem_Stall), 0);
      chk("rnd_strobe_expected", 32'(aln_q.size() != 0), 1);
      if (aln_q.size() != 0) begin
        cur_m = aln_q.pop_front();
        chk("rnd_strobe_addr", mem_Addr, cur_m.addr);
        chk("rnd_strobe_kind", 32'(mem_Wr), 32'(cur_m.wr));
        if (cur_m.wr) chk("rnd_strobe_data", mem_DataIn, cur_m.data);
      end
      out_m = 1;
      lat = $urandom_range(0, 4);
    end else if (out_m) lat--;
    if (out_m && lat == 0) begin
      e = ($urandom_range(0, 5) == 0);
      mem_Done = 1;
      mem_err = e;
      if (!cur_m.wr && !e) mem_DataOut = mem_m[cur_m.addr[8:1]];
      x.d = (cur_m.wr || e) ? 16'h0 : mem_m[cur_m.addr[8:1]];
      x.h = mem_CacheHit;
      x.e = e;
      res_q.push_back(x);
      if (cur_m.wr && !e) mem_m[cur_m.addr[8:1]] = cur_m.data;
      out_m = 0;
    end else if (!out_m && !(mem_Rd || mem_Wr) && $urandom_range(0, 7) == 0) begin
      mem_Done = 1;
      mem_err = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    if (req_valid && req_ready) begin
      r = '{req_wr, req_addr, req_data};
      req_q.push_back(r);
      if (!req_addr[0]) aln_q.push_back(r);
    end
    if (resp_valid) begin
      chk("rnd_resp_expected", 32'(req_q.size() != 0), 1);
      if (req_q.size() != 0) begin
        r = req_q.pop_front();
        x = '{16'h0, 1'b0, 1'b1};
        if (!r.addr[0]) begin
          chk("rnd_result_available", 32'(res_q.size() != 0), 1);
          if (res_q.size() != 0) x = res_q.pop_front();
        end
        if (!x.e) begin
          if (x.h) m_hc++;
          else m_mc++;
        end
        chk("rnd_resp_data", resp_data, x.d);
        chk("rnd_resp_hit", 32'(resp_hit), 32'(x.h));
        chk("rnd_resp_err", 32'(resp_err), 32'(x.e));
        chk("rnd_hit_cnt", hit_cnt, m_hc);
        chk("rnd_miss_cnt", miss_cnt, m_mc);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    for (int i = 0; i < 256; i++) mem_m[i] = 16'($urandom);
    //        v wr a       d        st dn ht er dout      rdy rd ws ma       rv rdat     rh re bsy hc mc
    tv[0]  = '{0, 0, 0,      0,       0, 0, 0, 0, 0,       1, 0, 0, 0,      0, 0,       0, 0, 0, 0, 0};
    tv[1]  = '{1, 0, 'h40,   0,       0, 0, 0, 0, 0,       1, 0, 0, 0,      0, 0,       0, 0, 0, 0, 0};
    tv[2]  = '{0, 0, 0,      0,       0, 1, 1, 0, 'hBEEF,  1, 1, 0, 'h40,   0, 0,       0, 0, 1, 0, 0};
    tv[3]  = '{0, 0, 0,      0,       0, 0, 0, 0, 0,       1, 0, 0, 'h40,   1, 'hBEEF,  1, 0, 0, 1, 0};
    tv[4]  = '{1, 0, 'h81,   0,       0, 0, 0, 0, 0,       1, 0, 0, 'h40,   0, 0,       0, 0, 0, 1, 0};
    tv[5]  = '{0, 0, 0,      0,       0, 0, 0, 0, 0,       1, 0, 0, 'h40,   0, 0,       0, 0, 1, 1, 0};
    tv[6]  = '{0, 0, 0,      0,       0, 0, 0, 0, 0,       1, 0, 0, 'h40,   1, 0,       0, 1, 0, 1, 0};
    tv[7]  = '{0, 0, 0,      0,       0, 1, 0, 0, 'h1111,  1, 0, 0, 'h40,   0, 0,       0, 0, 0, 1, 0};
    tv[8]  = '{0, 0, 0,      0,       0, 0, 0, 0, 0,       1, 0, 0, 'h40,   0, 0,       0, 0, 0, 1, 0};
    tv[9]  = '{1, 0, 'h10,   0,       0, 0, 0, 0, 0,       1, 0, 0, 'h40,   0, 0,       0, 0, 0, 1, 0};
    tv[10] = '{0, 0, 0,      0,       1, 0, 0, 0, 0,       1, 0, 0, 'h40,   0, 0,       0, 0, 1, 1, 0};
    tv[11] = '{0, 0, 0,      0,       0, 0, 0, 0, 0,       1, 1, 0, 'h10,   0, 0,       0, 0, 1, 1, 0};
    tv[12] = '{0, 0, 0,      0,       1, 1, 0, 1, 'hDEAD,  1, 0, 0, 'h10,   0, 0,       0, 0, 1, 1, 0};
    tv[13] = '{0, 0, 0,      0,       0, 0, 0, 0, 0,       1, 0, 0, 'h10,   1, 0,       0, 1, 0, 1, 0};
    tv[14] = '{1, 1, 'h200,  'hAAAA,  0, 0, 0, 0, 0,       1, 0, 0, 'h10,   0, 0,       0, 0, 0, 1, 0};
    tv[15] = '{1, 0, 'h202,  0,       0, 0, 0, 0, 0,       1, 0, 1, 'h200,  0, 0,       0, 0, 1, 1, 0};
    tv[16] = '{1, 0, 'h204,  0,       0, 0, 0, 0, 0,       1, 0, 0, 'h200,  0, 0,       0, 0, 1, 1, 0};
    tv[17] = '{1, 0, 'h206,  0,       0, 0, 0, 0, 0,       0, 0, 0, 'h200,  0, 0,       0, 0, 1, 1, 0};
    tv[18] = '{1, 0, 'h206,  0,       0, 1, 0, 0, 'h5555,  0, 0, 0, 'h200,  0, 0,       0, 0, 1, 1, 0};
    tv[19] = '{1, 0, 'h206,  0,       1, 0, 0, 0, 0,       0, 0, 0, 'h200,  1, 0,       0, 0, 1, 1, 1};
    tv[20] = '{1, 0, 'h206,  0,       0, 1, 1, 0, 'h0202,  0, 1, 0, 'h202,  0, 0,       0, 0, 1, 1, 1};
    tv[21] = '{1, 0, 'h206,  0,       0, 1, 1, 0, 'h0204,  1, 1, 0, 'h204,  1, 'h0202,  1, 0, 1, 2, 1};
    tv[22] = '{0, 0, 0,      0,       0, 0, 0, 0, 0,       1, 1, 0, 'h206,  1, 'h0204,  1, 0, 1, 3, 1};
    tv[23] = '{0, 0, 0,      0,       0, 1, 0, 0, 'h0206,  1, 0, 0, 'h206,  0, 0,       0, 0, 1, 3, 1};
    tv[24] = '{0, 0, 0,      0,       0, 0, 0, 0, 0,       1, 0, 0, 'h206,  1, 'h0206,  0, 0, 0, 3, 2};

    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 1);
    chk("reset_resp_valid", 32'(resp_valid), 0);
    chk("reset_mem_addr", mem_Addr, 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_hit_cnt", hit_cnt, 0);
    @(posedge clk); #1 rst = 0;

    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      req_valid = tv[i].v; req_wr = tv[i].wr; req_addr = tv[i].a; req_data = tv[i].d;
      mem_Stall = tv[i].st; mem_Done = tv[i].dn; mem_CacheHit = tv[i].ht;
      mem_err = tv[i].er; mem_DataOut = tv[i].dout;
      @(negedge clk);
      chk($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(tv[i].rdy));
      chk($sformatf("vec%0d_mem_Rd", i), 32'(mem_Rd), 32'(tv[i].rd));
      chk($sformatf("vec%0d_mem_Wr", i), 32'(mem_Wr), 32'(tv[i].ws));
      chk($sformatf("vec%0d_mem_Addr", i), mem_Addr, tv[i].ma);
      chk($sformatf("vec%0d_resp_valid", i), 32'(resp_valid), 32'(tv[i].rv));
      chk($sformatf("vec%0d_resp_data", i), resp_data, tv[i].rdat);
      chk($sformatf("vec%0d_resp_hit", i), 32'(resp_hit), 32'(tv[i].rh));
      chk($sformatf("vec%0d_resp_err", i), 32'(resp_err), 32'(tv[i].re));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tv[i].bsy));
      chk($sformatf("vec%0d_hit_cnt", i), hit_cnt, tv[i].hc);
      chk($sformatf("vec%0d_miss_cnt", i), miss_cnt, tv[i].mc);
    end

    // Store miss completing 12 cycles after its strobe.
    @(posedge clk); #1; idle();
    req_valid = 1; req_wr = 1; req_addr = 16'h0102; req_data = 16'h1234;
    @(negedge clk); chk("wm_ready", 32'(req_ready), 1);
    @(posedge clk); #1; idle();
    @(negedge clk);
    chk("wm_strobe", {30'd0, mem_Rd, mem_Wr}, 1);
    chk("wm_addr", mem_Addr, 16'h0102);
    chk("wm_din", mem_DataIn, 16'h1234);
    wcnt = int'(mem_Wr);
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1; mem_Done = (i == 12);
      @(negedge clk);
      wcnt += int'(mem_Wr) + int'(mem_Rd);
      chk($sformatf("wm_addr_hold%0d", i), mem_Addr, 16'h0102);
      chk($sformatf("wm_din_hold%0d", i), mem_DataIn, 16'h1234);
      chk($sformatf("wm_no_resp%0d", i), 32'(resp_valid), 0);
    end
    chk("wm_single_strobe", wcnt, 1);
    @(posedge clk); #1; idle();
    @(negedge clk);
    chk("wm_resp_valid", 32'(resp_valid), 1);
    chk("wm_resp_data", resp_data, 0);
    chk("wm_resp_err", 32'(resp_err), 0);
    chk("wm_miss_cnt", miss_cnt, 3);
    chk("wm_hit_cnt", hit_cnt, 3);

    // Reset while a request is outstanding and another is queued.
    @(posedge clk); #1; idle(); req_valid = 1; req_addr = 16'h0300;
    @(posedge clk); #1; req_addr = 16'h0302;
    @(posedge clk); #1; idle();
    @(negedge clk); chk("rst_pre_busy", 32'(busy), 1);
    #1 rst = 1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_addr", mem_Addr, 0);
    chk("rst_strobe", {30'd0, mem_Rd, mem_Wr}, 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1; mem_Done = 1; mem_CacheHit = 1;
      @(negedge clk);
      chk($sformatf("rst_after_resp%0d", i), 32'(resp_valid), 0);
      chk($sformatf("rst_after_strobe%0d", i), {30'd0, mem_Rd, mem_Wr}, 0);
    end

    // Back-to-back hits; the CNT_W=2 instance must saturate at 3.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      req_valid = (i < 5); req_wr = 0; req_addr = 16'h0400 + 16'(2 * i);
      mem_Done = 1; mem_CacheHit = 1; mem_DataOut = 16'h0077;
      @(negedge clk);
      chk($sformatf("b2b_resp_valid%0d", i), 32'(resp_valid), 32'(i >= 2 && i <= 6));
      if (i >= 2 && i <= 6) chk($sformatf("b2b_resp_data%0d", i), resp_data, 16'h0077);
    end
    chk("sat_hit_cnt16", hit_cnt, 5);
    chk("sat_hit_cnt2", 32'(hit_cnt_2), 3);
    chk("sat_miss_cnt2", 32'(miss_cnt_2), 0);

    m_hc = 5;
    m_mc = 0;
    for (int c = 0; c < 2500; c++) rand_cycle(1);
    for (int c = 0; c < 300; c++) begin
      if (req_q.size() == 0 && !out_m) break;
      rand_cycle(0);
    end
    chk("drain_pending_requests", req_q.size(), 0);
    chk("drain_outstanding", 32'(out_m), 0);
    chk("final_hit_cnt", hit_cnt, m_hc);
    chk("final_miss_cnt", miss_cnt, m_mc);
    chk("final_hit_cnt2", 32'(hit_cnt_2), 3);
    chk("final_miss_cnt2", 32'(miss_cnt_2), (m_mc > 3) ? 3 : m_mc);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mem_req_ctrl.md
# mem_req_ctrl

Pipeline-side initiator for the memory system: accepts load/store requests from the execute/memory stage, buffers up to two in a FIFO, and drives the cache's Addr/DataIn/Rd/Wr request interface. It honours the cache's Stall/Done handshake and returns one response per request in order. It also rejects misaligned accesses locally and keeps saturating hit/miss counters. It sits between the processor memory stage and `mem_system`.

## Interface
- CNT_W, 16, width of hit/miss counters
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  pipeline request present
- req_ready  out  1  request accepted this cycle when req_valid & req_ready
- req_wr  in  1  1 = store, 0 = load
- req_addr  in  16  byte address
- req_data  in  16  store data
- resp_valid  out  1  one-cycle response pulse
- resp_data  out  16  load data; 0 for stores and errors
- resp_hit  out  1  CacheHit captured at Done
- resp_err  out  1  misaligned, or mem err captured at Done
- mem_Addr  out  16  to memory system
- mem_DataIn  out  16  to memory system
- mem_Rd  out  1  read strobe
- mem_Wr  out  1  write strobe
- mem_DataOut  in  16  from memory system
- mem_Done  in  1  request complete, same cycle as data
- mem_Stall  in  1  memory system busy; no new strobe allowed
- mem_CacheHit  in  1  valid with mem_Done
- mem_err  in  1  valid with mem_Done
- busy  out  1  FIFO non-empty or request outstanding
- hit_cnt, miss_cnt  out  CNT_W each  saturating counts of completed, non-error requests

## Operation
- FIFO: 2 entries of {wr, addr, data}. `req_ready = !full`, combinational. Push occurs on `req_valid & req_ready`. Push and pop in the same cycle are legal at any occupancy.
- States:
  - IDLE: no outstanding request.
  - WAIT: a strobe has been issued and Done has not yet been seen.
- Issue condition: in IDLE, with the FIFO non-empty, head aligned (`addr[0]=0`), and `mem_Stall=0`.
  - Drive mem_Rd or mem_Wr for exactly that one cycle.
  - Pop the head into a held request register. mem_Addr/mem_DataIn come from this register and stay stable until Done.
  - mem_Rd/mem_Wr are low in every other cycle. Both are never high together.
- Done on the issue cycle (hit): complete immediately and stay in IDLE. Otherwise go to WAIT.
- WAIT: on mem_Done, complete and return to IDLE. The controller does not issue in the same cycle that Done arrives in WAIT.
- Completion: capture the response for the next cycle.
  - resp_data = mem_DataOut on a read, 0 on a write.
  - resp_hit = mem_CacheHit.
  - resp_err = mem_err.
  - Increment hit_cnt or miss_cnt, saturating at all-ones; not incremented when mem_err=1.
- Misaligned head in IDLE: pop it without any strobe. Next cycle: resp_valid=1, resp_err=1, resp_data=0, resp_hit=0. Counters are unchanged.
- mem_Done in IDLE with no strobe that cycle is ignored.
- Responses are returned in request order. There is no resp_ready; the consumer must accept every pulse.

## Timing
- Reset values: all registered outputs 0, state IDLE, FIFO empty, counters 0. req_ready=1 while rst is high.
- Reset mid-request discards the FIFO and the held request; no response is produced. The memory system shares rst.
- Hit latency: request accepted cycle N, strobe cycle N+1, resp_valid cycle N+2.
- Back-to-back hits sustain one response per cycle.
- Miss latency: strobe cycle S, Done cycle D, resp_valid cycle D+1. The next strobe is no earlier than D+1.
- While mem_Stall=1, no strobe is issued and the head waits. Stall has no effect once a request is in WAIT.
- busy is combinational: FIFO non-empty OR state=WAIT.

## Structure
- Package `mem_req_pkg`:
  - state enum {IDLE, WAIT}
  - localparams ADDR_W=16, DATA_W=16, FIFO_DEPTH=2
  - packed request struct {wr, addr, data}
- Sub-module `req_fifo`: 2-entry synchronous FIFO with push/pop/full/empty, asynchronous reset.
- Top level holds the FSM, held request register, response registers and counters.

## Test plan
- Read hit: load 0x0040 with mem_Done=1 and mem_CacheHit=1 on the strobe cycle, DataOut 0xBEEF -> resp_valid two cycles after acceptance, resp_data 0xBEEF, resp_hit=1, hit_cnt=1.
- Write miss: store 0x1234 to 0x0102, Done 12 cycles after the strobe -> mem_Addr/mem_DataIn held for 12 cycles, mem_Wr high exactly one cycle, resp_data 0, miss_cnt=1.
- Misaligned: load 0x0081 -> no mem_Rd, next-cycle resp_err=1, counters unchanged.
- Backpressure: three back-to-back requests during a miss -> req_ready=0 while two are queued, responses in order, no strobe while mem_Stall=1.
- Error and reset:
  - mem_err=1 at Done -> resp_err=1, no counter change.
  - rst asserted in WAIT -> all outputs 0 immediately and no response afterwards.
- Saturation: CNT_W=2 with five hits -> hit_cnt stays at 3.
